// File: rtl/cla32_pkg.sv
// Shared types for the cla32 adder result path.
package cla32_pkg;

  localparam int CLA_WIDTH = 32;

  typedef struct packed {
    logic                 cout;
    logic [CLA_WIDTH-1:0] sum;
  } cla_result_t;

  typedef struct packed {
    logic v;
    logic z;
  } cla_flags_t;

endpackage

// File: rtl/cla32_valid_pipe.sv
// Tracks which adder cycles carry accepted operands, LAT stages deep.
// Operand sign bits ride along when CLA32_RESULT_FLAGS_EN is defined.
module cla32_valid_pipe
  import cla32_pkg::*;
#(
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
`ifdef CLA32_RESULT_FLAGS_EN
  input  logic a_msb,
  input  logic b_msb,
  output logic out_a_msb,
  output logic out_b_msb,
`endif
  output logic out_valid
);

  logic [LAT-1:0] v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      v[0] <= in_valid;
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
      end
    end
  end

  assign out_valid = v[LAT-1];

`ifdef CLA32_RESULT_FLAGS_EN
  logic [LAT-1:0] am;
  logic [LAT-1:0] bm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      am <= '0;
      bm <= '0;
    end else if (flush) begin
      am <= '0;
      bm <= '0;
    end else begin
      am[0] <= a_msb;
      bm[0] <= b_msb;
      for (int i = 1; i < LAT; i++) begin
        am[i] <= am[i-1];
        bm[i] <= bm[i-1];
      end
    end
  end

  assign out_a_msb = am[LAT-1];
  assign out_b_msb = bm[LAT-1];
`endif

endmodule

// File: rtl/cla32_result_buffer.sv
// Credit-based result FIFO behind the pipelined CLA adder.
// Define CLA32_RESULT_FLAGS_EN to store and present {V, Z} per result.
module cla32_result_buffer
  import cla32_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         sum_in,
  input  logic                     cout_in,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic                     out_cout,
`ifdef CLA32_RESULT_FLAGS_EN
  input  logic                     a_msb,
  input  logic                     b_msb,
  output logic [1:0]               out_flags,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          acc;
  logic          pop;
  logic          wr;
  logic          push;
  logic [CW-1:0] used;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [WIDTH-1:0] sum_mem  [DEPTH];
  logic             cout_mem [DEPTH];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A slot is reserved at accept time, so a write can never find the FIFO full
  assign in_ready  = (used < CW'(DEPTH)) & ~flush;
  assign acc       = in_valid & in_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready & ~flush;
  assign push      = wr & ~flush;

`ifdef CLA32_RESULT_FLAGS_EN
  logic       wr_a_msb;
  logic       wr_b_msb;
  cla_flags_t flags_mem [DEPTH];
  cla_flags_t wr_flags;

  cla32_valid_pipe #(
    .LAT       (LAT)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (acc),
    .a_msb     (a_msb),
    .b_msb     (b_msb),
    .out_a_msb (wr_a_msb),
    .out_b_msb (wr_b_msb),
    .out_valid (wr)
  );

  always_comb begin
    wr_flags   = '0;
    wr_flags.v = (wr_a_msb == wr_b_msb) &
                 (sum_in[WIDTH-1] != wr_a_msb);
    wr_flags.z = (sum_in == '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      flags_mem[wr_ptr] <= wr_flags;
    end
  end

  assign out_flags = out_valid ? flags_mem[rd_ptr] : 2'b00;
`else
  cla32_valid_pipe #(
    .LAT       (LAT)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (acc),
    .out_valid (wr)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used <= '0;
    end else if (flush) begin
      used <= '0;
    end else if (acc & ~pop) begin
      used <= used + 1'b1;
    end else if (pop & ~acc) begin
      used <= used - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= nxt(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      if (push & ~pop) begin
        count <= count + 1'b1;
      end else if (pop & ~push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      sum_mem[wr_ptr]  <= sum_in;
      cout_mem[wr_ptr] <= cout_in;
    end
  end

  // Gated so an empty or just-reset FIFO presents zeros, not stale storage
  assign out_sum  = out_valid ? sum_mem[rd_ptr] : '0;
  assign out_cout = out_valid & cout_mem[rd_ptr];

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && count == CW'(DEPTH))
  );

endmodule

// File: tb/tb_cla32_result_buffer.sv
// Scoreboard bench for cla32_result_buffer with a latency-LAT adder model.
module tb_cla32_result_buffer;
  import cla32_pkg::*;

  localparam int W     = 32;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_cout;
  logic          cout_in;
  logic [W-1:0]  sum_in;
  logic [W-1:0]  out_sum;
  logic [CW-1:0] count;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
`ifdef CLA32_RESULT_FLAGS_EN
  logic          a_msb;
  logic          b_msb;
  logic [1:0]    out_flags;
  assign a_msb = op_a[W-1];
  assign b_msb = op_b[W-1];
`endif

  always #5 clk = ~clk;

  cla32_result_buffer #(
    .WIDTH     (W),
    .LAT       (LAT),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .cout_in   (cout_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
`ifdef CLA32_RESULT_FLAGS_EN
    .a_msb     (a_msb),
    .b_msb     (b_msb),
    .out_flags (out_flags),
`endif
    .count     (count)
  );

  // Pipelined adder model: operands in cycle t, sum valid in cycle t+LAT
  cla_result_t apipe [LAT];
  always_ff @(posedge clk) begin
    apipe[0] <= {1'b0, op_a} + {1'b0, op_b};
    for (int i = 1; i < LAT; i++) begin
      apipe[i] <= apipe[i-1];
    end
  end
  assign sum_in  = apipe[LAT-1].sum;
  assign cout_in = apipe[LAT-1].cout;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic [1:0]   flags;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;
  int acc_n = 0;
  int pop_n = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive after negedge, sample mid-cycle, update scoreboard
  task automatic cyc(input logic v, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic ordy,
                     input logic fl);
    int         fifo_n;
    logic       rdy_m;
    logic [W:0] s;
    exp_t       e;
    @(negedge clk);
    cyc_n++;
    in_valid  = v;
    op_a      = a;
    op_b      = b;
    out_ready = ordy;
    flush     = fl;
    #2;
    fifo_n = 0;
    foreach (q[i]) if (q[i].cyc + LAT < cyc_n) fifo_n++;
    rdy_m = !fl && (q.size() < DEPTH);
    check("in_ready", in_ready, rdy_m);
    check("count", count, fifo_n);
    check("out_valid", out_valid, fifo_n > 0);
    if (fl) begin
      q.delete();
    end else begin
      if (fifo_n > 0 && ordy) begin
        check("out_sum", out_sum, q[0].sum);
        check("out_cout", out_cout, q[0].cout);
`ifdef CLA32_RESULT_FLAGS_EN
        check("out_flags", out_flags, q[0].flags);
`endif
        void'(q.pop_front());
        pop_n++;
      end
      if (v && rdy_m) begin
        s       = {1'b0, a} + {1'b0, b};
        e.sum   = s[W-1:0];
        e.cout  = s[W];
        e.flags = {(a[W-1] == b[W-1]) && (s[W-1] != a[W-1]),
                   s[W-1:0] == '0};
        e.cyc   = cyc_n;
        q.push_back(e);
        acc_n++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_cout", out_cout, 0);
`ifdef CLA32_RESULT_FLAGS_EN
    check("rst_out_flags", out_flags, 0);
`endif
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic one_op(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    int t;
    cyc(1, a, b, 0, 0);
    t = cyc_n;
    for (int i = 0; i < 10 && !out_valid; i++) cyc(0, 0, 0, 0, 0);
    check({tag, "_latency"}, cyc_n - t, LAT + 1);
    check({tag, "_sum"}, out_sum, a + b);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    check({tag, "_count0"}, count, 0);
  endtask

  initial begin
    logic [W-1:0] ta [10];
    logic [W-1:0] tb [10];
    int k;
    int a0;
    int p0;
    int seen;

    do_reset();

    one_op("basic", 35, 88);

    // Backpressure: credits stop acceptance at DEPTH
    a0 = acc_n;
    for (int i = 0; i < 6; i++) cyc(1, 32'h100 * i, i, 0, 0);
    check("bp_accepts", acc_n - a0, 4);
    check("bp_ready_low", in_ready, 0);
    for (int i = 0; i < 8 && count != 4; i++) cyc(0, 0, 0, 0, 0);
    check("bp_full", count, 4);
    cyc(0, 0, 0, 1, 0);
    check("bp_ready_at_pop", in_ready, 0);
    cyc(0, 0, 0, 1, 0);
    check("bp_ready_after_pop", in_ready, 1);
    for (int i = 0; i < 8 && q.size() > 0; i++) cyc(0, 0, 0, 1, 0);
    check("bp_drained", q.size(), 0);

    // Streaming with out_ready held high
    ta[0] = 32'h7FFF_FFFF; tb[0] = 32'h0000_0001;
    ta[1] = 32'hFFFF_FFFF; tb[1] = 32'h0000_0001;
    ta[2] = 32'h8000_0000; tb[2] = 32'h8000_0000;
    ta[3] = 32'h0000_0000; tb[3] = 32'h0000_0000;
    for (int i = 4; i < 10; i++) begin
      ta[i] = $urandom;
      tb[i] = $urandom;
    end
    a0 = acc_n;
    p0 = pop_n;
    k  = 0;
    for (int i = 0; i < 60 && k < 10; i++) begin
      cyc(1, ta[k], tb[k], 1, 0);
      k = acc_n - a0;
    end
    for (int i = 0; i < 12 && q.size() > 0; i++) cyc(0, 0, 0, 1, 0);
    check("tp_accepts", acc_n - a0, 10);
    check("tp_results", pop_n - p0, 10);

    // Flags corner cases and the wrap-to-zero sum
    one_op("ovf", 32'h7FFF_FFFF, 32'h0000_0001);
    cyc(1, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0);
    for (int i = 0; i < 10 && !out_valid; i++) cyc(0, 0, 0, 0, 0);
    check("zero_sum", out_sum, 0);
    check("zero_cout", out_cout, 1);
`ifdef CLA32_RESULT_FLAGS_EN
    check("zero_flags", out_flags, 2'b01);
`endif
    cyc(0, 0, 0, 1, 0);

    // Flush with one stored and two in flight
    cyc(1, 1, 2, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 3, 4, 0, 0);
    cyc(1, 5, 6, 0, 0);
    check("pre_flush_count", count, 1);
    cyc(0, 0, 0, 1, 1);
    check("flush_ready", in_ready, 0);
    cyc(0, 0, 0, 1, 0);
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 1, 0);
      if (out_valid) seen++;
    end
    check("flush_no_emerge", seen, 0);

    // Reset mid-stream, then a clean op
    cyc(1, 10, 20, 0, 0);
    cyc(1, 30, 40, 0, 0);
    cyc(0, 0, 0, 0, 0);
    do_reset();
    one_op("post_rst", 100, 200);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
